// File: rtl/dispatch_stage_if.sv
// Fetch-to-dispatch bus carrying one pre-decoded instruction per transfer.
// Handshake: an instruction moves on a clock edge where in_valid && in_ready; the producer holds its fields while in_valid is high and in_ready is low.
interface dispatch_stage_if #(
  parameter int XLEN  = 32,
  parameter int OP_W  = 6,
  parameter int IMM_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_next_pc;
  logic [OP_W-1:0]  in_op;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [IMM_W-1:0] in_imm;
  logic [1:0]       in_class;

  modport master (
    output in_valid, in_pc, in_next_pc, in_op, in_rd, in_rs1, in_rs2, in_imm, in_class,
    input  in_ready
  );
  modport slave (
    input  in_valid, in_pc, in_next_pc, in_op, in_rd, in_rs1, in_rs2, in_imm, in_class,
    output in_ready
  );
endinterface

// File: rtl/dispatch_stage.sv
// In-order issue stage: buffers fetched instructions, allocates a ROB tag, renames rd and
// sends resolved operands to the reservation station or the load/store buffer.
module dispatch_stage #(
  parameter int QUEUE_DEPTH = 4,
  parameter int XLEN        = 32,
  parameter int ROB_ID_W    = 4,
  parameter int OP_W        = 6,
  parameter int IMM_W       = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        flush,
  dispatch_stage_if.slave             fetch,
  output logic [4:0]                  rs1_to_rf,
  output logic [4:0]                  rs2_to_rf,
  input  logic [ROB_ID_W-1:0]         qj_from_rf,
  input  logic [ROB_ID_W-1:0]         qk_from_rf,
  input  logic [XLEN-1:0]             vj_from_rf,
  input  logic [XLEN-1:0]             vk_from_rf,
  output logic [ROB_ID_W-1:0]         qj_to_rob,
  output logic [ROB_ID_W-1:0]         qk_to_rob,
  input  logic                        vj_valid_from_rob,
  input  logic                        vk_valid_from_rob,
  input  logic [XLEN-1:0]             vj_from_rob,
  input  logic [XLEN-1:0]             vk_from_rob,
  input  logic                        cdb_valid,
  input  logic [ROB_ID_W-1:0]         cdb_id,
  input  logic [XLEN-1:0]             cdb_value,
  input  logic [ROB_ID_W-1:0]         rob_free_id,
  input  logic                        rob_full,
  input  logic                        rs_full,
  input  logic                        lsb_full,
  output logic                        rob_valid,
  output logic [1:0]                  rob_signal,
  output logic [4:0]                  rob_rd,
  output logic [XLEN-1:0]             rob_pc,
  output logic [XLEN-1:0]             rob_next_pc,
  output logic [4:0]                  rf_rd,
  output logic [ROB_ID_W-1:0]         rf_dest,
  output logic [ROB_ID_W-1:0]         rs_dest,
  output logic [ROB_ID_W-1:0]         rs_qj,
  output logic [ROB_ID_W-1:0]         rs_qk,
  output logic [OP_W-1:0]             rs_op,
  output logic [XLEN-1:0]             rs_vj,
  output logic [XLEN-1:0]             rs_vk,
  output logic [XLEN-1:0]             rs_pc,
  output logic [IMM_W-1:0]            rs_imm,
  output logic [ROB_ID_W-1:0]         lsb_dest,
  output logic [ROB_ID_W-1:0]         lsb_qj,
  output logic [ROB_ID_W-1:0]         lsb_qk,
  output logic [OP_W-1:0]             lsb_op,
  output logic [XLEN-1:0]             lsb_vj,
  output logic [XLEN-1:0]             lsb_vk,
  output logic [IMM_W-1:0]            lsb_imm,
  output logic [$clog2(QUEUE_DEPTH):0] fifo_count
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(QUEUE_DEPTH);
  localparam logic [1:0] CLS_NORMAL = 2'd0;
  localparam logic [1:0] CLS_LOAD   = 2'd1;
  localparam logic [1:0] CLS_STORE  = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  next_pc;
    logic [OP_W-1:0]  op;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [IMM_W-1:0] imm;
    logic [1:0]       cls;
  } entry_t;

  entry_t              mem [QUEUE_DEPTH];
  entry_t              in_e;
  entry_t              head_e;
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [PTR_W:0]      count;
  logic                enq;
  logic                fire;
  logic                head_mem;
  logic                renames;
  logic                clear;
  logic [ROB_ID_W-1:0] qj;
  logic [ROB_ID_W-1:0] qk;
  logic [XLEN-1:0]     vj;
  logic [XLEN-1:0]     vk;

  assign in_e = '{pc: fetch.in_pc, next_pc: fetch.in_next_pc, op: fetch.in_op,
                  rd: fetch.in_rd, rs1: fetch.in_rs1, rs2: fetch.in_rs2,
                  imm: fetch.in_imm, cls: fetch.in_class};
  assign head_e         = mem[head];
  assign clear          = rst || flush;
  assign fetch.in_ready = (count < DEPTH_CNT);
  assign fifo_count     = count;
  assign enq            = rdy && fetch.in_valid && fetch.in_ready;
  assign head_mem       = (head_e.cls == CLS_LOAD) || (head_e.cls == CLS_STORE);
  // Only the unit the head instruction targets can stall it.
  assign fire           = rdy && (count != '0) && !rob_full && (head_mem ? !lsb_full : !rs_full);
  assign renames        = ((head_e.cls == CLS_NORMAL) || (head_e.cls == CLS_LOAD)) && (head_e.rd != 5'd0);

  assign rs1_to_rf = head_e.rs1;
  assign rs2_to_rf = head_e.rs2;
  assign qj_to_rob = qj_from_rf;
  assign qk_to_rob = qk_from_rf;

  // Returns {tag, value}; the last-cycle rename (rf_rd/rf_dest) is not yet visible in the RF.
  function automatic logic [ROB_ID_W+XLEN-1:0] resolve(
    input logic [4:0]          rs,
    input logic [4:0]          byp_rd,
    input logic [ROB_ID_W-1:0] byp_tag,
    input logic [ROB_ID_W-1:0] q_rf,
    input logic [XLEN-1:0]     v_rf,
    input logic                rob_ok,
    input logic [XLEN-1:0]     v_rob,
    input logic                cdb_ok,
    input logic [ROB_ID_W-1:0] cdb_tag,
    input logic [XLEN-1:0]     cdb_v
  );
    if (rs == 5'd0)                      return '0;
    else if (byp_rd == rs)               return {byp_tag, {XLEN{1'b0}}};
    else if (q_rf == '0)                 return {{ROB_ID_W{1'b0}}, v_rf};
    else if (rob_ok)                     return {{ROB_ID_W{1'b0}}, v_rob};
    else if (cdb_ok && cdb_tag == q_rf)  return {{ROB_ID_W{1'b0}}, cdb_v};
    else                                 return {q_rf, {XLEN{1'b0}}};
  endfunction

  always_comb begin
    {qj, vj} = resolve(head_e.rs1, rf_rd, rf_dest, qj_from_rf, vj_from_rf,
                       vj_valid_from_rob, vj_from_rob, cdb_valid, cdb_id, cdb_value);
    {qk, vk} = resolve(head_e.rs2, rf_rd, rf_dest, qk_from_rf, vk_from_rf,
                       vk_valid_from_rob, vk_from_rob, cdb_valid, cdb_id, cdb_value);
  end

  always_ff @(posedge clk) begin
    if (!clear && enq) mem[tail] <= in_e;
  end

  // rf_rd/rf_dest double as the rename bypass register: written on every fire, zeroed otherwise.
  always_ff @(posedge clk) begin
    if (clear) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rob_valid <= 1'b0;
      rf_rd     <= 5'd0;
      rs_dest   <= '0;
      lsb_dest  <= '0;
    end else if (rdy) begin
      if (enq)  tail <= tail + 1'b1;
      if (fire) head <= head + 1'b1;
      case ({enq, fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      rob_valid <= fire;
      rf_rd     <= (fire && renames) ? head_e.rd : 5'd0;
      rs_dest   <= (fire && !head_mem) ? rob_free_id : '0;
      lsb_dest  <= (fire && head_mem) ? rob_free_id : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear && fire) begin
      rob_signal  <= head_e.cls;
      rob_rd      <= head_e.rd;
      rob_pc      <= head_e.pc;
      rob_next_pc <= head_e.next_pc;
      rf_dest     <= rob_free_id;
      if (head_mem) begin
        lsb_op  <= head_e.op;
        lsb_imm <= head_e.imm;
        lsb_qj  <= qj;
        lsb_qk  <= qk;
        lsb_vj  <= vj;
        lsb_vk  <= vk;
      end else begin
        rs_op  <= head_e.op;
        rs_imm <= head_e.imm;
        rs_pc  <= head_e.pc;
        rs_qj  <= qj;
        rs_qk  <= qk;
        rs_vj  <= vj;
        rs_vk  <= vk;
      end
    end
  end
endmodule

// File: tb/tb_dispatch_stage.sv
// Bench for dispatch_stage: directed sequences, an operand-source vector table and a random phase,
// all scored against a queue-based model of the stage's rules.
module tb_dispatch_stage;
  localparam int XLEN  = 32;
  localparam int RW    = 4;
  localparam int OW    = 6;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, rdy, flush;
  logic [4:0]    rs1_to_rf, rs2_to_rf;
  logic [RW-1:0] qj_from_rf, qk_from_rf, qj_to_rob, qk_to_rob;
  logic [XLEN-1:0] vj_from_rf, vk_from_rf, vj_from_rob, vk_from_rob, cdb_value;
  logic vj_valid_from_rob, vk_valid_from_rob, cdb_valid;
  logic [RW-1:0] cdb_id, rob_free_id;
  logic rob_full, rs_full, lsb_full;
  logic rob_valid;
  logic [1:0] rob_signal;
  logic [4:0] rob_rd, rf_rd;
  logic [XLEN-1:0] rob_pc, rob_next_pc, rs_vj, rs_vk, rs_pc, lsb_vj, lsb_vk;
  logic [RW-1:0] rf_dest, rs_dest, rs_qj, rs_qk, lsb_dest, lsb_qj, lsb_qk;
  logic [OW-1:0] rs_op, lsb_op;
  logic [IW-1:0] rs_imm, lsb_imm;
  logic [2:0] fifo_count;

  dispatch_stage_if #(.XLEN(XLEN), .OP_W(OW), .IMM_W(IW)) fetch ();

  dispatch_stage #(.QUEUE_DEPTH(DEPTH), .XLEN(XLEN), .ROB_ID_W(RW), .OP_W(OW), .IMM_W(IW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .fetch(fetch),
    .rs1_to_rf(rs1_to_rf), .rs2_to_rf(rs2_to_rf),
    .qj_from_rf(qj_from_rf), .qk_from_rf(qk_from_rf), .vj_from_rf(vj_from_rf), .vk_from_rf(vk_from_rf),
    .qj_to_rob(qj_to_rob), .qk_to_rob(qk_to_rob),
    .vj_valid_from_rob(vj_valid_from_rob), .vk_valid_from_rob(vk_valid_from_rob),
    .vj_from_rob(vj_from_rob), .vk_from_rob(vk_from_rob),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_value(cdb_value),
    .rob_free_id(rob_free_id), .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .rob_valid(rob_valid), .rob_signal(rob_signal), .rob_rd(rob_rd), .rob_pc(rob_pc), .rob_next_pc(rob_next_pc),
    .rf_rd(rf_rd), .rf_dest(rf_dest),
    .rs_dest(rs_dest), .rs_qj(rs_qj), .rs_qk(rs_qk), .rs_op(rs_op), .rs_vj(rs_vj), .rs_vk(rs_vk),
    .rs_pc(rs_pc), .rs_imm(rs_imm),
    .lsb_dest(lsb_dest), .lsb_qj(lsb_qj), .lsb_qk(lsb_qk), .lsb_op(lsb_op), .lsb_vj(lsb_vj), .lsb_vk(lsb_vk),
    .lsb_imm(lsb_imm), .fifo_count(fifo_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model state / scoreboard ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [1:0]  cls;
  } ent_t;
  localparam int EW = $bits(ent_t);
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic rob_valid; logic [1:0] rob_signal; logic [4:0] rob_rd; logic [31:0] rob_pc, rob_next_pc;
    logic [4:0] rf_rd; logic [3:0] rf_dest;
    logic [3:0] rs_dest, rs_qj, rs_qk; logic [5:0] rs_op; logic [31:0] rs_vj, rs_vk, rs_pc, rs_imm;
    logic [3:0] lsb_dest, lsb_qj, lsb_qk; logic [5:0] lsb_op; logic [31:0] lsb_vj, lsb_vk, lsb_imm;
  } out_t;
  out_t exp_o;
  logic [4:0]  m_byp_rd;
  logic [3:0]  m_byp_dest;
  logic [31:0] pc_ctr;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Operand rules in priority order: x0, last-cycle rename, RF ready, ROB ready, CDB, wait on tag.
  task automatic m_resolve(input logic [4:0] rs, input logic [3:0] q_rf, input logic [31:0] v_rf,
                           input logic rob_ok, input logic [31:0] v_rob,
                           output logic [3:0] q, output logic [31:0] v);
    q = 4'd0; v = 32'd0;
    if (rs == 5'd0) begin end
    else if (m_byp_rd == rs) q = m_byp_dest;
    else if (q_rf == 4'd0) v = v_rf;
    else if (rob_ok) v = v_rob;
    else if (cdb_valid && cdb_id == q_rf) v = cdb_value;
    else q = q_rf;
  endtask

  task automatic model_step();
    ent_t h, n;
    bit f, e, is_mem;
    logic [3:0] qj, qk;
    logic [31:0] vj, vk;
    if (rst || flush) begin
      exp_q.delete();
      exp_o.rob_valid = 1'b0; exp_o.rf_rd = 5'd0; exp_o.rs_dest = 4'd0; exp_o.lsb_dest = 4'd0;
      m_byp_rd = 5'd0;
    end else if (rdy) begin
      f = 1'b0; is_mem = 1'b0;
      h = '0;
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        is_mem = (h.cls == 2'd1) || (h.cls == 2'd2);
        f = !rob_full && (is_mem ? !lsb_full : !rs_full);
      end
      e = fetch.in_valid && (exp_q.size() < DEPTH);
      exp_o.rob_valid = f; exp_o.rf_rd = 5'd0; exp_o.rs_dest = 4'd0; exp_o.lsb_dest = 4'd0;
      if (f) begin
        m_resolve(h.rs1, qj_from_rf, vj_from_rf, vj_valid_from_rob, vj_from_rob, qj, vj);
        m_resolve(h.rs2, qk_from_rf, vk_from_rf, vk_valid_from_rob, vk_from_rob, qk, vk);
        exp_o.rob_signal = h.cls; exp_o.rob_rd = h.rd; exp_o.rob_pc = h.pc; exp_o.rob_next_pc = h.next_pc;
        if (h.cls <= 2'd1 && h.rd != 5'd0) begin
          exp_o.rf_rd = h.rd; exp_o.rf_dest = rob_free_id;
        end
        if (is_mem) begin
          exp_o.lsb_dest = rob_free_id; exp_o.lsb_op = h.op; exp_o.lsb_imm = h.imm;
          exp_o.lsb_qj = qj; exp_o.lsb_qk = qk; exp_o.lsb_vj = vj; exp_o.lsb_vk = vk;
        end else begin
          exp_o.rs_dest = rob_free_id; exp_o.rs_op = h.op; exp_o.rs_imm = h.imm; exp_o.rs_pc = h.pc;
          exp_o.rs_qj = qj; exp_o.rs_qk = qk; exp_o.rs_vj = vj; exp_o.rs_vk = vk;
        end
        void'(exp_q.pop_front());
      end
      m_byp_rd = exp_o.rf_rd; m_byp_dest = exp_o.rf_dest;
      if (e) begin
        n.pc = fetch.in_pc; n.next_pc = fetch.in_next_pc; n.op = fetch.in_op; n.rd = fetch.in_rd;
        n.rs1 = fetch.in_rs1; n.rs2 = fetch.in_rs2; n.imm = fetch.in_imm; n.cls = fetch.in_class;
        exp_q.push_back(n);
      end
    end
  endtask

  task automatic compare_all();
    ent_t h;
    chk("rob_valid", rob_valid, exp_o.rob_valid);
    chk("rf_rd", rf_rd, exp_o.rf_rd);
    chk("rs_dest", rs_dest, exp_o.rs_dest);
    chk("lsb_dest", lsb_dest, exp_o.lsb_dest);
    if (exp_o.rob_valid) begin
      chk("rob_signal", rob_signal, exp_o.rob_signal);
      chk("rob_rd", rob_rd, exp_o.rob_rd);
      chk("rob_pc", rob_pc, exp_o.rob_pc);
      chk("rob_next_pc", rob_next_pc, exp_o.rob_next_pc);
    end
    if (exp_o.rf_rd != 5'd0) chk("rf_dest", rf_dest, exp_o.rf_dest);
    if (exp_o.rs_dest != 4'd0) begin
      chk("rs_op", rs_op, exp_o.rs_op); chk("rs_imm", rs_imm, exp_o.rs_imm); chk("rs_pc", rs_pc, exp_o.rs_pc);
      chk("rs_qj", rs_qj, exp_o.rs_qj); chk("rs_qk", rs_qk, exp_o.rs_qk);
      chk("rs_vj", rs_vj, exp_o.rs_vj); chk("rs_vk", rs_vk, exp_o.rs_vk);
    end
    if (exp_o.lsb_dest != 4'd0) begin
      chk("lsb_op", lsb_op, exp_o.lsb_op); chk("lsb_imm", lsb_imm, exp_o.lsb_imm);
      chk("lsb_qj", lsb_qj, exp_o.lsb_qj); chk("lsb_qk", lsb_qk, exp_o.lsb_qk);
      chk("lsb_vj", lsb_vj, exp_o.lsb_vj); chk("lsb_vk", lsb_vk, exp_o.lsb_vk);
    end
    chk("fifo_count", fifo_count, exp_q.size());
    chk("in_ready", fetch.in_ready, exp_q.size() < DEPTH);
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      chk("rs1_to_rf", rs1_to_rf, h.rs1);
      chk("rs2_to_rf", rs2_to_rf, h.rs2);
    end
    chk("qj_to_rob", qj_to_rob, qj_from_rf);
    chk("qk_to_rob", qk_to_rob, qk_from_rf);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic defaults();
    rst = 1'b0; flush = 1'b0; rdy = 1'b1;
    fetch.in_valid = 1'b0;
    qj_from_rf = '0; qk_from_rf = '0; vj_from_rf = '0; vk_from_rf = '0;
    vj_valid_from_rob = 1'b0; vk_valid_from_rob = 1'b0; vj_from_rob = '0; vk_from_rob = '0;
    cdb_valid = 1'b0; cdb_id = '0; cdb_value = '0;
    rob_free_id = 4'd1; rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
  endtask

  task automatic push(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic [1:0] cls);
    fetch.in_valid = 1'b1; fetch.in_pc = pc_ctr; fetch.in_next_pc = pc_ctr + 32'd4;
    fetch.in_op = op; fetch.in_rd = rd; fetch.in_rs1 = rs1; fetch.in_rs2 = rs2;
    fetch.in_imm = imm; fetch.in_class = cls;
    pc_ctr = pc_ctr + 32'd4;
  endtask

  task automatic no_ins();
    fetch.in_valid = 1'b0;
  endtask

  // ---------------- operand vector table ----------------
  typedef struct {
    logic [4:0] rs1, rs2; logic [3:0] qj_rf, qk_rf; logic [31:0] vj_rf, vk_rf;
    logic jv, kv; logic [31:0] jrob, krob; logic cv; logic [3:0] cid; logic [31:0] cval;
    logic [3:0] eqj, eqk; logic [31:0] evj, evk;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{5'd1, 5'd2, 4'd2, 4'd0, 32'h0, 32'h22, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 4'd0, 32'h0,
                4'd0, 4'd0, 32'h10, 32'h22};
    vecs[1] = '{5'd3, 5'd4, 4'd0, 4'd4, 32'hAB, 32'h5, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 4'd4, 32'h77,
                4'd0, 4'd0, 32'hAB, 32'h77};
    vecs[2] = '{5'd5, 5'd0, 4'd6, 4'd7, 32'h3, 32'h4, 1'b0, 1'b1, 32'h0, 32'h9, 1'b1, 4'd2, 32'h1,
                4'd6, 4'd0, 32'h0, 32'h0};
    vecs[3] = '{5'd9, 5'd10, 4'd5, 4'd3, 32'h0, 32'h0, 1'b1, 1'b0, 32'h11, 32'h22, 1'b1, 4'd5, 32'h99,
                4'd0, 4'd3, 32'h11, 32'h0};
    vecs[4] = '{5'd0, 5'd2, 4'd0, 4'd0, 32'hDEAD, 32'h1234, 1'b1, 1'b0, 32'h5, 32'h0, 1'b0, 4'd0, 32'h0,
                4'd0, 4'd0, 32'h0, 32'h1234};
    vecs[5] = '{5'd12, 5'd13, 4'd1, 4'd1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h44, 1'b1, 4'd1, 32'h88,
                4'd0, 4'd0, 32'h88, 32'h44};

    pc_ctr = 32'h1000;
    exp_o = '{default: '0};
    m_byp_rd = 5'd0; m_byp_dest = 4'd0;
    fetch.in_pc = '0; fetch.in_next_pc = '0; fetch.in_op = '0; fetch.in_rd = '0;
    fetch.in_rs1 = '0; fetch.in_rs2 = '0; fetch.in_imm = '0; fetch.in_class = '0;
    defaults();

    // ---- reset ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_rob_valid", rob_valid, 0);
    chk("reset_rf_rd", rf_rd, 0);
    chk("reset_rs_dest", rs_dest, 0);
    chk("reset_lsb_dest", lsb_dest, 0);
    chk("reset_in_ready", fetch.in_ready, 1);

    // ---- flush drops queue and a same-cycle enqueue ----
    rs_full = 1'b1;
    for (int i = 0; i < 3; i++) begin push(6'h13, 5'(i + 1), 5'd0, 5'd0, 32'(i), 2'd0); tick(); end
    chk("flush_pre_count", fifo_count, 3);
    flush = 1'b1;
    push(6'h13, 5'd4, 5'd0, 5'd0, 32'd9, 2'd0);
    tick();
    flush = 1'b0; no_ins(); rs_full = 1'b0;
    chk("flush_count", fifo_count, 0);
    chk("flush_in_ready", fetch.in_ready, 1);
    chk("flush_rob_valid", rob_valid, 0);
    tick();
    chk("flush_no_dispatch", rob_valid, 0);

    // ---- back-pressure: rs_full stalls addi at head, lw behind it waits ----
    rs_full = 1'b1;
    push(6'h13, 5'd1, 5'd0, 5'd0, 32'd5, 2'd0); tick();
    push(6'h03, 5'd2, 5'd3, 5'd0, 32'd0, 2'd1); tick();
    no_ins();
    tick(); chk("bp_stall0", rob_valid, 0);
    tick(); chk("bp_stall1", rob_valid, 0);
    chk("bp_count", fifo_count, 2);
    rs_full = 1'b0; rob_free_id = 4'd1; qj_from_rf = 4'd5; vj_from_rf = 32'h5555;
    tick();
    chk("bp_addi_valid", rob_valid, 1);
    chk("bp_addi_rs_dest", rs_dest, 1);
    chk("bp_addi_qj", rs_qj, 0);
    chk("bp_addi_vj", rs_vj, 0);
    chk("bp_addi_imm", rs_imm, 5);
    rob_free_id = 4'd2; qj_from_rf = 4'd0; vj_from_rf = 32'h100;
    tick();
    chk("bp_lw_lsb_dest", lsb_dest, 2);
    chk("bp_lw_rs_dest", rs_dest, 0);
    chk("bp_lw_vj", lsb_vj, 32'h100);
    defaults();

    // ---- rename bypass: back-to-back dependent instructions ----
    push(6'h13, 5'd5, 5'd0, 5'd0, 32'd1, 2'd0); tick();
    rob_free_id = 4'd3;
    push(6'h33, 5'd6, 5'd5, 5'd5, 32'd0, 2'd0); tick();
    chk("byp_addi_rf_rd", rf_rd, 5);
    no_ins(); rob_free_id = 4'd4; vj_from_rf = 32'h55; vk_from_rf = 32'h55;
    tick();
    chk("byp_qj", rs_qj, 3);
    chk("byp_qk", rs_qk, 3);
    chk("byp_vj", rs_vj, 0);
    chk("byp_vk", rs_vk, 0);
    defaults();
    tick();

    // ---- operand sources, table-driven ----
    for (int i = 0; i < 6; i++) begin
      push(6'h33, 5'd20, vecs[i].rs1, vecs[i].rs2, 32'd0, 2'd0);
      tick();
      no_ins(); rob_free_id = 4'd7;
      qj_from_rf = vecs[i].qj_rf; qk_from_rf = vecs[i].qk_rf;
      vj_from_rf = vecs[i].vj_rf; vk_from_rf = vecs[i].vk_rf;
      vj_valid_from_rob = vecs[i].jv; vk_valid_from_rob = vecs[i].kv;
      vj_from_rob = vecs[i].jrob; vk_from_rob = vecs[i].krob;
      cdb_valid = vecs[i].cv; cdb_id = vecs[i].cid; cdb_value = vecs[i].cval;
      tick();
      chk($sformatf("vec%0d_dest", i), rs_dest, 7);
      chk($sformatf("vec%0d_qj", i), rs_qj, vecs[i].eqj);
      chk($sformatf("vec%0d_vj", i), rs_vj, vecs[i].evj);
      chk($sformatf("vec%0d_qk", i), rs_qk, vecs[i].eqk);
      chk($sformatf("vec%0d_vk", i), rs_vk, vecs[i].evk);
      defaults();
    end

    // ---- store (not blocked by rs_full), branch, write to x0 ----
    rs_full = 1'b1; rob_free_id = 4'd5;
    push(6'h23, 5'd7, 5'd8, 5'd7, 32'd4, 2'd2); tick();
    no_ins(); tick();
    chk("sw_valid", rob_valid, 1);
    chk("sw_signal", rob_signal, 2);
    chk("sw_rf_rd", rf_rd, 0);
    chk("sw_lsb_imm", lsb_imm, 4);
    chk("sw_lsb_dest", lsb_dest, 5);
    rs_full = 1'b0; rob_free_id = 4'd6;
    push(6'h63, 5'd9, 5'd1, 5'd2, 32'h10, 2'd3); tick();
    no_ins(); tick();
    chk("beq_signal", rob_signal, 3);
    chk("beq_rf_rd", rf_rd, 0);
    chk("beq_rs_dest", rs_dest, 6);
    push(6'h13, 5'd0, 5'd1, 5'd0, 32'd3, 2'd0); tick();
    no_ins(); tick();
    chk("x0_valid", rob_valid, 1);
    chk("x0_rf_rd", rf_rd, 0);

    // ---- full, freeze, wrap ----
    rs_full = 1'b1;
    for (int i = 0; i < 4; i++) begin push(6'h13, 5'(i + 1), 5'd0, 5'd0, 32'(i), 2'd0); tick(); end
    chk("full_in_ready", fetch.in_ready, 0);
    push(6'h13, 5'd9, 5'd0, 5'd0, 32'd99, 2'd0); tick();
    chk("full_drop_count", fifo_count, 4);
    rs_full = 1'b0; rdy = 1'b0; tick();
    chk("freeze_idle_valid", rob_valid, 0);
    chk("freeze_idle_count", fifo_count, 4);
    rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rob_free_id = 4'(i + 1);
      push(6'h13, 5'(i % 7 + 1), 5'd0, 5'd0, 32'(i + 100), 2'(i % 2));
      tick();
      chk("wrap_count", fifo_count, 3);
      if (i == 4) begin
        rdy = 1'b0; tick();
        chk("freeze_valid", rob_valid, 1);
        chk("freeze_count", fifo_count, 3);
        rdy = 1'b1;
      end
    end
    no_ins();
    for (int i = 0; i < 5; i++) tick();
    chk("drain_count", fifo_count, 0);

    // ---- random phase ----
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 59) == 0);
      rob_full = ($urandom_range(0, 5) == 0);
      rs_full = ($urandom_range(0, 3) == 0);
      lsb_full = ($urandom_range(0, 3) == 0);
      rob_free_id = 4'($urandom_range(1, 15));
      qj_from_rf = 4'($urandom_range(0, 3)); qk_from_rf = 4'($urandom_range(0, 3));
      vj_from_rf = $urandom; vk_from_rf = $urandom;
      vj_valid_from_rob = 1'($urandom_range(0, 1)); vk_valid_from_rob = 1'($urandom_range(0, 1));
      vj_from_rob = $urandom; vk_from_rob = $urandom;
      cdb_valid = 1'($urandom_range(0, 1)); cdb_id = 4'($urandom_range(0, 3)); cdb_value = $urandom;
      if ($urandom_range(0, 2) != 0)
        push(6'($urandom_range(0, 63)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), $urandom, 2'($urandom_range(0, 3)));
      else
        no_ins();
      tick();
      chk("count_bound", fifo_count <= 3'(DEPTH), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
